// File: rtl/vram_arb_pkg.sv
// Shared types and requester indices for the VRAM CPU-port arbiter.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic REQ_MU  = 1'b0;
    localparam logic REQ_BLT = 1'b1;

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Requester pair plus VRAM cpu-side port, bundled for the arbiter.
interface vram_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_d;
    logic              r0_ack;
    logic [DATA_W-1:0] r0_q;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_d;
    logic              r1_ack;
    logic [DATA_W-1:0] r1_q;

    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_d;
    logic              vram_we;
    logic [DATA_W-1:0] vram_q;

    // Requesters and the VRAM model sit on the master side.
    modport master (
        output r0_req, r0_we, r0_addr, r0_d,
        input  r0_ack, r0_q,
        output r1_req, r1_we, r1_addr, r1_d,
        input  r1_ack, r1_q,
        input  vram_addr, vram_d, vram_we,
        output vram_q
    );

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_d,
        output r0_ack, r0_q,
        input  r1_req, r1_we, r1_addr, r1_d,
        output r1_ack, r1_q,
        output vram_addr, vram_d, vram_we,
        input  vram_q
    );

endinterface

// File: rtl/vram_arb_pick.sv
// Combinational winner select between two requesters; zero latency.
// Round-robin on ties with VRAM_ARB_RR_EN, otherwise requester 0 always wins.
module vram_arb_pick (
    input  logic r0_req,
    input  logic r1_req,
`ifdef VRAM_ARB_RR_EN
    input  logic last,
`endif
    output logic grant,
    output logic grant_vld
);
    import vram_arb_pkg::*;

    always_comb begin
        grant_vld = r0_req | r1_req;
        grant     = REQ_MU;
        if (r1_req && !r0_req) begin
            grant = REQ_BLT;
        end
`ifdef VRAM_ARB_RR_EN
        // Tie: hand the port to whoever did not win last time.
        else if (r1_req && r0_req && (last == REQ_MU)) begin
            grant = REQ_BLT;
        end
`endif
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Two-requester arbiter for one VRAM cpu port: write acks 2 cycles after grant, read 3.
// Loser's req is held pending; define VRAM_ARB_RR_EN for round-robin ties, else fixed priority.
module vram_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    vram_port_arbiter_if.slave   bus
);
    import vram_arb_pkg::*;

    state_t            state;
    logic              win;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] d_r;
    logic              vram_we_r;
    logic              ack0_r;
    logic              ack1_r;
    logic [DATA_W-1:0] q0_r;
    logic [DATA_W-1:0] q1_r;
    logic              grant;
    logic              grant_vld;
`ifdef VRAM_ARB_RR_EN
    logic              last;
`endif

    vram_arb_pick u_pick (
        .r0_req    (bus.r0_req),
        .r1_req    (bus.r1_req),
`ifdef VRAM_ARB_RR_EN
        .last      (last),
`endif
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            win       <= REQ_MU;
            we_r      <= 1'b0;
            addr_r    <= '0;
            d_r       <= '0;
            vram_we_r <= 1'b0;
            ack0_r    <= 1'b0;
            ack1_r    <= 1'b0;
            q0_r      <= '0;
            q1_r      <= '0;
`ifdef VRAM_ARB_RR_EN
            last      <= REQ_BLT;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        win <= grant;
                        if (grant == REQ_BLT) begin
                            addr_r    <= bus.r1_addr;
                            d_r       <= bus.r1_d;
                            we_r      <= bus.r1_we;
                            vram_we_r <= bus.r1_we;
                        end else begin
                            addr_r    <= bus.r0_addr;
                            d_r       <= bus.r0_d;
                            we_r      <= bus.r0_we;
                            vram_we_r <= bus.r0_we;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // vram_we was registered on grant so it is high for ISSUE only.
                    vram_we_r <= 1'b0;
                    if (we_r) begin
                        ack0_r <= (win == REQ_MU);
                        ack1_r <= (win == REQ_BLT);
                        state  <= DONE;
                    end else begin
                        state  <= READ;
                    end
                end
                READ: begin
                    if (win == REQ_BLT) begin
                        q1_r   <= bus.vram_q;
                        ack1_r <= 1'b1;
                    end else begin
                        q0_r   <= bus.vram_q;
                        ack0_r <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    ack0_r <= 1'b0;
                    ack1_r <= 1'b0;
`ifdef VRAM_ARB_RR_EN
                    last   <= win;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.vram_addr = addr_r;
    assign bus.vram_d    = d_r;
    assign bus.vram_we   = vram_we_r;
    assign bus.r0_ack    = ack0_r;
    assign bus.r1_ack    = ack1_r;
    assign bus.r0_q      = q0_r;
    assign bus.r1_q      = q1_r;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a VRAM model and an ack scoreboard.
module tb_vram_port_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 14;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   we_cnt = 0;
    int   last_we_cyc = -1;

    typedef struct {
        int          r;
        bit          we;
        logic [31:0] q;
    } exp_t;
    exp_t sb[$];

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    vram_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    vram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // VRAM model: registered read, one-cycle latency.
    always @(posedge clk) begin
        if (bus.vram_we) mem[bus.vram_addr] <= bus.vram_d;
        bus.vram_q <= mem[bus.vram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop the scoreboard on every ack.
    always @(negedge clk) begin
        exp_t e;
        if (bus.vram_we === 1'b1) begin
            we_cnt++;
            last_we_cyc = cyc;
        end
        if (bus.r0_ack === 1'b1 && bus.r1_ack === 1'b1) begin
            check("dual_ack", 32'd1, 32'd0);
        end else if (bus.r0_ack === 1'b1 || bus.r1_ack === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {31'd0, bus.r1_ack}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("ack_owner", {31'd0, bus.r1_ack}, e.r[31:0]);
                if (!e.we) check("read_q", bus.r1_ack ? bus.r1_q : bus.r0_q, e.q);
            end
        end
    end

    task automatic push(input int r, input bit we, input logic [31:0] q);
        exp_t e;
        e.r = r; e.we = we; e.q = q;
        sb.push_back(e);
    endtask

    task automatic do_req(input int r, input bit we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input int exp_lat, output int ack_cyc);
        int start;
        bit seen;
        if (r == 0) begin
            bus.r0_we = we; bus.r0_addr = a; bus.r0_d = d; bus.r0_req = 1'b1;
        end else begin
            bus.r1_we = we; bus.r1_addr = a; bus.r1_d = d; bus.r1_req = 1'b1;
        end
        start = cyc;
        seen  = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if ((r == 0 && bus.r0_ack === 1'b1) || (r == 1 && bus.r1_ack === 1'b1)) seen = 1'b1;
        end
        ack_cyc = cyc;
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
        else if (exp_lat >= 0) check("ack_latency", cyc - start, exp_lat);
        @(posedge clk); #1;
        if (r == 0) bus.r0_req = 1'b0;
        else        bus.r1_req = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_r0_ack", {31'd0, bus.r0_ack}, 32'd0);
        check("rst_r1_ack", {31'd0, bus.r1_ack}, 32'd0);
        check("rst_vram_we", {31'd0, bus.vram_we}, 32'd0);
        check("rst_vram_addr", {18'd0, bus.vram_addr}, 32'd0);
        check("rst_vram_d", bus.vram_d, 32'd0);
        check("rst_r0_q", bus.r0_q, 32'd0);
        check("rst_r1_q", bus.r1_q, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ac, ac_a, ac_b, prev, w0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[1] = 32'h11;
        mem[2] = 32'h22;
        mem[3] = 32'h33;
        bus.r0_req = 0; bus.r0_we = 0; bus.r0_addr = '0; bus.r0_d = '0;
        bus.r1_req = 0; bus.r1_we = 0; bus.r1_addr = '0; bus.r1_d = '0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single write then read-back by r0.
        push(0, 1, 32'h0);
        w0 = we_cnt;
        do_req(0, 1, 14'h0010, 32'hDEADBEEF, 2, ac);
        check("wr_we_pulses", we_cnt - w0, 1);
        check("wr_we_cycle", last_we_cyc, ac - 1);
        push(0, 0, 32'hDEADBEEF);
        w0 = we_cnt;
        do_req(0, 0, 14'h0010, 32'h0, 3, ac);
        check("rd_we_pulses", we_cnt - w0, 0);
        check("rd_r0_q", bus.r0_q, 32'hDEADBEEF);

        // Simultaneous back-to-back reads from both requesters.
`ifdef VRAM_ARB_RR_EN
        push(0, 0, 32'h11); push(1, 0, 32'h22); push(0, 0, 32'h11); push(1, 0, 32'h22);
`else
        push(0, 0, 32'h11); push(0, 0, 32'h11); push(1, 0, 32'h22); push(1, 0, 32'h22);
`endif
        fork
            begin
                do_req(0, 0, 14'h0001, 32'h0, -1, ac_a);
                do_req(0, 0, 14'h0001, 32'h0, -1, ac_a);
            end
            begin
                do_req(1, 0, 14'h0002, 32'h0, -1, ac_b);
                do_req(1, 0, 14'h0002, 32'h0, -1, ac_b);
            end
        join

        // r1 arrives while r0's read is in ISSUE.
        push(0, 0, 32'h11);
        push(1, 0, 32'h33);
        fork
            do_req(0, 0, 14'h0001, 32'h0, 3, ac_a);
            begin
                @(posedge clk); #1;
                do_req(1, 0, 14'h0003, 32'h0, 6, ac_b);
            end
        join
        check("late_r0_q_kept", bus.r0_q, 32'h11);
        check("late_r1_q", bus.r1_q, 32'h33);

        // Reset while r0 read is in READ.
        bus.r0_we = 1'b0; bus.r0_addr = 14'h0002; bus.r0_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.r0_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_vals();
        push(0, 1, 32'h0);
        do_req(0, 1, 14'h0020, 32'hCAFEF00D, 2, ac);
        check("post_rst_mem", mem[14'h0020], 32'hCAFEF00D);

        // Eight back-to-back r0 writes.
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            push(0, 1, 32'h0);
            do_req(0, 1, i[ADDR_W-1:0], i, 2, ac);
            if (i > 0) check("wr_spacing", ac - prev, 3);
            prev = ac;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) check("burst_mem", mem[i], i);

        repeat (4) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
